// File: rtl/writeback_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_regfile_if
// Description : Bundles the writeback and decode-read signals of the register
//               file. The master is the pipeline and the slave is the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface writeback_regfile_if;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] pc_plus_fourW;
    logic [4:0]  RdW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] ResultW;
    logic [31:0] WriteCount;

    modport master (
        output RegWriteW, ResultSrcW, ALUResultW, ReadDataW, pc_plus_fourW, RdW, A1, A2,
        input  RD1, RD2, ResultW, WriteCount
    );

    modport slave (
        input  RegWriteW, ResultSrcW, ALUResultW, ReadDataW, pc_plus_fourW, RdW, A1, A2,
        output RD1, RD2, ResultW, WriteCount
    );
endinterface
`default_nettype wire

// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module      : writeback_regfile
// Description : Writeback result mux plus a 32x32 register file with
//               write-through bypass on both read ports and a write counter.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_regfile #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    writeback_regfile_if.slave   wb
);

    localparam logic [1:0] c_SRC_ALU  = 2'b00;
    localparam logic [1:0] c_SRC_LOAD = 2'b01;
    localparam logic [1:0] c_SRC_LINK = 2'b10;

    logic [31:0] r_regs [0:31];
    logic [31:0] r_writeCount;
    logic [31:0] w_result;
    logic        w_commit;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;

    // Reserved select value yields zero, so reserved writes store 0.
    always_comb begin
        w_result = 32'h0;
        case (wb.ResultSrcW)
            c_SRC_ALU:  w_result = wb.ALUResultW;
            c_SRC_LOAD: w_result = wb.ReadDataW;
            c_SRC_LINK: w_result = wb.pc_plus_fourW;
            default:    w_result = 32'h0;
        endcase
    end

    assign w_commit = wb.RegWriteW && (wb.RdW != 5'd0) && !reset;

    generate
        if (CLEAR_ON_RESET) begin : g_clear
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < 32; i++) begin
                        r_regs[i] <= 32'h0;
                    end
                end else if (w_commit) begin
                    r_regs[wb.RdW] <= w_result;
                end
            end
        end else begin : g_keep
            always_ff @(posedge clk) begin
                if (w_commit) begin
                    r_regs[wb.RdW] <= w_result;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_writeCount <= 32'h0;
        end else if (w_commit) begin
            r_writeCount <= r_writeCount + 32'd1;
        end
    end

    // w_commit already excludes x0 and reset, so it doubles as the bypass qualifier.
    always_comb begin
        w_rd1 = 32'h0;
        if (wb.A1 != 5'd0) begin
            if (w_commit && (wb.A1 == wb.RdW)) begin
                w_rd1 = w_result;
            end else begin
                w_rd1 = r_regs[wb.A1];
            end
        end
    end

    always_comb begin
        w_rd2 = 32'h0;
        if (wb.A2 != 5'd0) begin
            if (w_commit && (wb.A2 == wb.RdW)) begin
                w_rd2 = w_result;
            end else begin
                w_rd2 = r_regs[wb.A2];
            end
        end
    end

    assign wb.ResultW    = w_result;
    assign wb.RD1        = w_rd1;
    assign wb.RD2        = w_rd2;
    assign wb.WriteCount = r_writeCount;

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_regfile
// Description : Directed self-checking bench for writeback_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] expCount;

    writeback_regfile_if wbIf ();

    writeback_regfile #(.CLEAR_ON_RESET(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wbIf.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic we, input logic [1:0] src, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [31:0] pc4, input logic [4:0] rd,
                         input logic [4:0] a1, input logic [4:0] a2);
        wbIf.RegWriteW     = we;
        wbIf.ResultSrcW    = src;
        wbIf.ALUResultW    = alu;
        wbIf.ReadDataW     = ld;
        wbIf.pc_plus_fourW = pc4;
        wbIf.RdW           = rd;
        wbIf.A1            = a1;
        wbIf.A2            = a2;
    endtask

    task automatic read_only(input logic [4:0] a1, input logic [4:0] a2);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, a1, a2);
    endtask

    // Advance across one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        read_only(5'd0, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (wbIf.WriteCount !== 32'h0) begin
            errors++;
            $display("FAIL reset_count: got %h expected %h", wbIf.WriteCount, 32'h0);
        end
        expCount = 32'h0;
        for (int i = 0; i < 32; i++) begin
            read_only(5'(i), 5'(31 - i));
            #1;
            checks++;
            if (wbIf.RD1 !== 32'h0 || wbIf.RD2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_clear x%0d: got RD1=%h RD2=%h expected 0", i, wbIf.RD1, wbIf.RD2);
            end
        end
    endtask

    task automatic test_basic_write();
        @(negedge clk);
        drive(1'b1, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 5'd0, 5'd0);
        step();
        read_only(5'd5, 5'd0);
        expCount = expCount + 32'd1;
        #1;
        checks++;
        if (wbIf.RD1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_read: got %h expected %h", wbIf.RD1, 32'hDEADBEEF);
        end
        checks++;
        if (wbIf.WriteCount !== 32'd1) begin
            errors++;
            $display("FAIL basic_count: got %h expected %h", wbIf.WriteCount, 32'd1);
        end
    endtask

    task automatic test_source_select();
        logic [1:0]  srcs [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [31:0] exps [4] = '{32'h0000_0A1A, 32'h11, 32'h104, 32'h0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b1, srcs[k], 32'h0000_0A1A, 32'h11, 32'h104, 5'd7, 5'd0, 5'd0);
            #1;
            checks++;
            if (wbIf.ResultW !== exps[k]) begin
                errors++;
                $display("FAIL src_result sel=%b: got %h expected %h", srcs[k], wbIf.ResultW, exps[k]);
            end
            step();
            read_only(5'd0, 5'd7);
            expCount = expCount + 32'd1;
            #1;
            checks++;
            if (wbIf.RD2 !== exps[k]) begin
                errors++;
                $display("FAIL src_readback sel=%b: got %h expected %h", srcs[k], wbIf.RD2, exps[k]);
            end
        end
        checks++;
        if (wbIf.WriteCount !== expCount) begin
            errors++;
            $display("FAIL src_count: got %h expected %h", wbIf.WriteCount, expCount);
        end
    endtask

    task automatic test_x0_protect();
        @(negedge clk);
        drive(1'b1, 2'b00, 32'hFFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (wbIf.RD1 !== 32'h0) begin
            errors++;
            $display("FAIL x0_same_cycle: got %h expected %h", wbIf.RD1, 32'h0);
        end
        step();
        read_only(5'd0, 5'd0);
        #1;
        checks++;
        if (wbIf.RD1 !== 32'h0) begin
            errors++;
            $display("FAIL x0_next_cycle: got %h expected %h", wbIf.RD1, 32'h0);
        end
        checks++;
        if (wbIf.WriteCount !== expCount) begin
            errors++;
            $display("FAIL x0_count: got %h expected %h", wbIf.WriteCount, expCount);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        drive(1'b1, 2'b00, 32'h1, 32'h0, 32'h0, 5'd9, 5'd0, 5'd0);
        step();
        expCount = expCount + 32'd1;
        drive(1'b1, 2'b00, 32'h2, 32'h0, 32'h0, 5'd9, 5'd9, 5'd9);
        #1;
        checks++;
        if (wbIf.RD1 !== 32'h2 || wbIf.RD2 !== 32'h2) begin
            errors++;
            $display("FAIL bypass_both: got RD1=%h RD2=%h expected %h", wbIf.RD1, wbIf.RD2, 32'h2);
        end
        step();
        expCount = expCount + 32'd1;
        // Only port 1 matches the destination; port 2 must see stored x5.
        drive(1'b1, 2'b00, 32'h3, 32'h0, 32'h0, 5'd9, 5'd9, 5'd5);
        #1;
        checks++;
        if (wbIf.RD1 !== 32'h3 || wbIf.RD2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_indep: got RD1=%h RD2=%h expected 3/deadbeef", wbIf.RD1, wbIf.RD2);
        end
        step();
        expCount = expCount + 32'd1;
        read_only(5'd9, 5'd0);
        #1;
        checks++;
        if (wbIf.RD1 !== 32'h3) begin
            errors++;
            $display("FAIL bypass_stored: got %h expected %h", wbIf.RD1, 32'h3);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(1'b1, 2'b00, 32'h100, 32'h0, 32'h0, 5'd10, 5'd0, 5'd0);
        step();
        drive(1'b1, 2'b01, 32'h0, 32'h200, 32'h0, 5'd10, 5'd0, 5'd0);
        step();
        expCount = expCount + 32'd2;
        read_only(5'd10, 5'd10);
        #1;
        checks++;
        if (wbIf.RD1 !== 32'h200) begin
            errors++;
            $display("FAIL b2b_value: got %h expected %h", wbIf.RD1, 32'h200);
        end
        checks++;
        if (wbIf.WriteCount !== expCount) begin
            errors++;
            $display("FAIL b2b_count: got %h expected %h", wbIf.WriteCount, expCount);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        dut.r_writeCount = 32'hFFFF_FFFF;
        drive(1'b1, 2'b00, 32'h77, 32'h0, 32'h0, 5'd12, 5'd0, 5'd0);
        step();
        read_only(5'd12, 5'd0);
        expCount = 32'h0;
        #1;
        checks++;
        if (wbIf.WriteCount !== 32'h0) begin
            errors++;
            $display("FAIL wrap_count: got %h expected %h", wbIf.WriteCount, 32'h0);
        end
        checks++;
        if (wbIf.RD1 !== 32'h77) begin
            errors++;
            $display("FAIL wrap_write: got %h expected %h", wbIf.RD1, 32'h77);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(1'b1, 2'b00, 32'h55, 32'h0, 32'h0, 5'd3, 5'd0, 5'd0);
        step();
        reset = 1'b1;
        drive(1'b1, 2'b00, 32'hA5, 32'h0, 32'h0, 5'd3, 5'd3, 5'd0);
        #1;
        checks++;
        if (wbIf.RD1 !== 32'h55) begin
            errors++;
            $display("FAIL rstmid_nobypass: got %h expected %h", wbIf.RD1, 32'h55);
        end
        step();
        reset = 1'b0;
        read_only(5'd3, 5'd9);
        #1;
        checks++;
        if (wbIf.RD1 !== 32'h0 || wbIf.RD2 !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_clear: got x3=%h x9=%h expected 0", wbIf.RD1, wbIf.RD2);
        end
        checks++;
        if (wbIf.WriteCount !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_count: got %h expected %h", wbIf.WriteCount, 32'h0);
        end
        drive(1'b1, 2'b10, 32'h0, 32'h0, 32'h8, 5'd4, 5'd0, 5'd0);
        step();
        read_only(5'd4, 5'd0);
        #1;
        checks++;
        if (wbIf.WriteCount !== 32'd1 || wbIf.RD1 !== 32'h8) begin
            errors++;
            $display("FAIL rstmid_first_write: got count=%h x4=%h expected 1/8", wbIf.WriteCount, wbIf.RD1);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        expCount = 32'h0;
        reset    = 1'b1;
        read_only(5'd0, 5'd0);
        test_reset();
        test_basic_write();
        test_source_select();
        test_x0_protect();
        test_bypass();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001: Parameter CLEAR_ON_RESET, default 1. 1 = reset clears x1..x31; 0 = reset leaves register contents unchanged.
REQ-002: clk  input  1  single clock; all state updates on posedge clk.
REQ-003: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004: RegWriteW  input  1  writeback enable from the MEM/WB pipeline register.
REQ-005: ResultSrcW  input  2  result select: 00 ALU result, 01 load data, 10 PC+4, 11 reserved.
REQ-006: ALUResultW  input  32  ALU result from MEM/WB.
REQ-007: ReadDataW  input  32  load data from MEM/WB.
REQ-008: pc_plus_fourW  input  32  link value from MEM/WB.
REQ-009: RdW  input  5  destination register index.
REQ-010: A1, A2  input  5 each  decode-stage source register indices.
REQ-011: RD1, RD2  output  32 each  decode-stage read data for A1 and A2.
REQ-012: ResultW  output  32  selected writeback value, driven to the EX forwarding mux.
REQ-013: WriteCount  output  32  count of committed register writes.

Function
REQ-014: ResultW SHALL be combinational: ALUResultW for 00, ReadDataW for 01, pc_plus_fourW for 10, and 32'h0 for 11.
REQ-015: Storage SHALL be 32 x 32-bit; x0 SHALL read 0 at all times and SHALL never be written.
REQ-016: A write is committed on posedge clk when RegWriteW=1, RdW!=0 and reset=0; regs[RdW] <= ResultW.
REQ-017: RegWriteW=1 with RdW=0 SHALL produce no write and no counter increment.
REQ-018: RD1 and RD2 SHALL be combinational, with zero-cycle read latency.
REQ-019: Write-through bypass: if reset=0, RegWriteW=1, RdW!=0 and Ax==RdW, then RDx SHALL equal ResultW in the same cycle. Otherwise RDx = regs[Ax], or 0 if Ax=0.
REQ-020: Both read ports SHALL bypass independently; A1==A2==RdW returns ResultW on both ports.
REQ-021: WriteCount SHALL increment by 1 on every committed write (REQ-016).
REQ-022: WriteCount SHALL wrap from 32'hFFFFFFFF to 0 with no flag.
REQ-023: Reserved ResultSrcW=11 with a valid write SHALL write 32'h0 and increment WriteCount.
REQ-024: Successive writes to the same RdW on back-to-back cycles: the later write wins, and each write counts.
REQ-025: No X SHALL propagate from unwritten registers after reset when CLEAR_ON_RESET=1.

Reset
REQ-026: With reset=1 at posedge clk, WriteCount SHALL become 0.
REQ-027: With reset=1 at posedge clk and CLEAR_ON_RESET=1, x1..x31 SHALL become 0.
REQ-028: With reset=1, no write SHALL be committed in that cycle regardless of RegWriteW, and the bypass of REQ-019 SHALL be disabled.
REQ-029: Reset asserted mid-stream SHALL take effect at the next edge. The first write after deassertion SHALL commit normally and set WriteCount=1.
REQ-030: Before the first reset edge, register contents and WriteCount are undefined. Benches SHALL apply reset for at least 1 cycle.

Verification
REQ-031: Basic write/read: reset, then write x5 with ResultSrcW=00, ALUResultW=32'hDEADBEEF. Next cycle A1=5 -> RD1=32'hDEADBEEF and WriteCount=1.
REQ-032: Source select: ResultSrcW=01/10/11 with ReadDataW=32'h11, pc_plus_fourW=32'h104 -> ResultW = 32'h11, 32'h104, 32'h0 respectively; x7 reads back each value.
REQ-033: x0 protection: RegWriteW=1, RdW=0, ALUResultW=32'hFFFF -> A1=0 gives RD1=0 on the same and the next cycle, and WriteCount is unchanged.
REQ-034: Same-cycle bypass: x9=32'h1 is stored; drive RegWriteW=1, RdW=9, ALUResultW=32'h2 with A1=A2=9 -> RD1=RD2=32'h2 in that cycle, and x9 reads 32'h2 afterwards.
REQ-035: Reset mid-operation: write x3=32'hA5 on the same edge that reset=1 -> x3 reads 0, WriteCount=0, and RD1 for A1=3 shows no bypass during the reset cycle.
REQ-036: Counter wrap: force WriteCount to 32'hFFFFFFFF via 2^32-1 writes or a backdoor, then commit one write -> WriteCount=0.
